pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Sequencing controller for the five-stage IF/ID/EX/MEM/WB datapath. Tracks destination registers
//  in flight, emits operand forwarding selects, stalls on load-use, squashes on taken branch, and
//  runs the reset-hold/run/halt FSM. Drives PC, IF/ID and ID/EX buffer enables; no data passes through it.
// PARAMETERS
//  REGISTER_SELECTOR_WIDTH  5   width of register selectors; register 0 is hardwired zero
//  SOURCE_SELECTOR_WIDTH    2   width of output source selector (0 ALU, 1 immediate, 2 zero, 3 memory)
//  FLUSH_CYCLES             2   squash cycles after branch_taken
//  RESET_HOLD_CYCLES        4   cycles held idle after reset release
//  STALL_COUNTER_WIDTH      16  width of the saturating stall counter
// PORTS
//  clock                         in   1    single clock, rising edge
//  reset_n                       in   1    asynchronous reset, active low
//  id_input_type_1/2             in   1    1 = operand is a register, 0 = immediate
//  id_input_register_selector_1/2 in  RSW  ID source registers
//  id_output_enable              in   1    ID instruction writes a register
//  id_output_source_selector     in   SSW  ID writeback source
//  id_output_register_selector   in   RSW  ID destination register
//  branch_taken                  in   1    EX resolved a taken branch this cycle
//  halt_request / resume_request in   1    single-cycle pulses from debug control
//  pc_enable                     out  1    program counter may advance
//  if_id_enable                  out  1    IF/ID buffer may load
//  if_id_flush                   out  1    IF/ID buffer loads a bubble
//  id_ex_bubble                  out  1    ID/EX buffer loads a bubble (output_enable=0)
//  forward_select_1/2            out  2    0 register file, 1 EX/MEM ALU result, 2 MEM/WB writeback data
//  halted                        out  1    FSM in HALTED
//  stall_count                   out  SCW  saturating count of stall+flush cycles
// BEHAVIOUR
//  Reset (reset_n=0, async): state RESET_HOLD, hold counter=RESET_HOLD_CYCLES-1, tracking regs empty,
//   pc_enable=0, if_id_enable=0, if_id_flush=1, id_ex_bubble=1, forward selects=0, halted=0, stall_count=0.
//  Tracking regs (registered): ex_{valid,dest,is_load}, mem_{valid,dest}. Each edge: mem<=ex;
//   ex<=ID fields if !id_ex_bubble else empty. valid = output_enable && dest!=0; is_load = source==3.
//  Forwarding (combinational, latched by ID/EX): per operand, if type=1, selector!=0:
//   matches ex_dest&&ex_valid -> 1; else matches mem_dest&&mem_valid -> 2; else 0. EX match wins.
//   WB needs none (register file is write-first).
//  Load-use: ex_valid && ex_is_load && any register operand matches ex_dest.
//  FSM states: RESET_HOLD, RUN, STALL, FLUSH, HALTED.
//   RESET_HOLD: counts down; at 0 -> RUN. Outputs as in reset.
//   RUN: pc_enable=1, if_id_enable=1, flush=0, bubble=0. Priority: branch_taken -> FLUSH;
//    else load-use -> STALL (same cycle: pc_enable=0, if_id_enable=0, id_ex_bubble=1);
//    else halt_request -> HALTED.
//   STALL: exactly one cycle, all go; -> RUN (next condition re-evaluated there).
//   FLUSH: if_id_flush=1, id_ex_bubble=1, pc_enable=1 for FLUSH_CYCLES cycles (counter); -> RUN.
//   HALTED: pc_enable=0, if_id_enable=0, id_ex_bubble=1 (pipeline drains); halted=1;
//    resume_request -> RUN.
//  Simultaneous: branch_taken + load-use -> FLUSH (dependent instruction squashed, no stall counted).
//   halt_request during STALL/FLUSH is latched in halt_pending, taken on the RUN entry cycle.
//   branch_taken in FLUSH/HALTED/RESET_HOLD ignored. resume without HALTED ignored.
//  stall_count +1 per cycle in STALL or FLUSH and per load-use cycle in RUN; saturates at all-ones.
//  Reset mid-operation: immediate async return to reset values; pending halt discarded.
// STRUCTURE
//  Shared package pipeline_control_package: state enum, source selector codes (SOURCE_ALU=0,
//   SOURCE_IMMEDIATE=1, SOURCE_ZERO=2, SOURCE_MEMORY=3), forward select codes, REGISTER_ZERO.
//  One sub-module: hazard_forwarding_unit (combinational compare of ID sources vs tracking regs).
// TESTING
//  Reset release -> pc_enable stays 0 for 4 cycles, 1 on cycle 5; if_id_flush 1 until then.
//  ADD r3 then ADD r4,r3,r3 -> forward_select_1=forward_select_2=1; next-but-one use of r3 -> 2.
//  LOAD r5 (source 3) then ADD r6,r5,r1 -> one cycle pc_enable=0, id_ex_bubble=1; then select 2, count=1.
//  Write to r0 then read r0 -> selects 0, no stall.
//  branch_taken with load-use same cycle -> 2 cycles if_id_flush=1, no STALL, stall_count +2.
//  halt_request during FLUSH -> HALTED after flush; resume_request -> RUN next cycle; reset_n low mid-STALL -> reset values.

Source files
------------

// File: rtl/pipeline_control_package.sv
// Shared constants for the five-stage pipeline sequencing controller.
package pipeline_control_package;

  // Controller FSM states
  localparam logic [2:0] STATE_RESET_HOLD = 3'd0;
  localparam logic [2:0] STATE_RUN        = 3'd1;
  localparam logic [2:0] STATE_STALL      = 3'd2;
  localparam logic [2:0] STATE_FLUSH      = 3'd3;
  localparam logic [2:0] STATE_HALTED     = 3'd4;

  // Writeback source selector codes
  localparam logic [1:0] SOURCE_ALU       = 2'd0;
  localparam logic [1:0] SOURCE_IMMEDIATE = 2'd1;
  localparam logic [1:0] SOURCE_ZERO      = 2'd2;
  localparam logic [1:0] SOURCE_MEMORY    = 2'd3;

  // Operand forwarding select codes
  localparam logic [1:0] FORWARD_REGISTER_FILE = 2'd0;
  localparam logic [1:0] FORWARD_EX_MEM        = 2'd1;
  localparam logic [1:0] FORWARD_MEM_WB        = 2'd2;

  // Register 0 reads as zero and is never a real destination
  localparam int REGISTER_ZERO = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Datapath <-> hazard controller signal bundle. The datapath is the master
// (presents the ID instruction and branch/debug events), the controller is the slave.
interface pipeline_hazard_controller_if #(
  parameter int RSW = 5,
  parameter int SSW = 2,
  parameter int SCW = 16
);
  logic           id_input_type_1;
  logic           id_input_type_2;
  logic [RSW-1:0] id_input_register_selector_1;
  logic [RSW-1:0] id_input_register_selector_2;
  logic           id_output_enable;
  logic [SSW-1:0] id_output_source_selector;
  logic [RSW-1:0] id_output_register_selector;
  logic           branch_taken;
  logic           halt_request;
  logic           resume_request;

  logic           pc_enable;
  logic           if_id_enable;
  logic           if_id_flush;
  logic           id_ex_bubble;
  logic [1:0]     forward_select_1;
  logic [1:0]     forward_select_2;
  logic           halted;
  logic [SCW-1:0] stall_count;

  modport master (
    output id_input_type_1, id_input_type_2,
           id_input_register_selector_1, id_input_register_selector_2,
           id_output_enable, id_output_source_selector, id_output_register_selector,
           branch_taken, halt_request, resume_request,
    input  pc_enable, if_id_enable, if_id_flush, id_ex_bubble,
           forward_select_1, forward_select_2, halted, stall_count
  );

  modport slave (
    input  id_input_type_1, id_input_type_2,
           id_input_register_selector_1, id_input_register_selector_2,
           id_output_enable, id_output_source_selector, id_output_register_selector,
           branch_taken, halt_request, resume_request,
    output pc_enable, if_id_enable, if_id_flush, id_ex_bubble,
           forward_select_1, forward_select_2, halted, stall_count
  );
endinterface

// File: rtl/hazard_forwarding_unit.sv
// Combinational compare of the two ID source operands against the EX and MEM
// destination tracking registers: forwarding selects plus load-use detect.
module hazard_forwarding_unit
  import pipeline_control_package::*;
#(
  parameter int RSW = 5
) (
  input  logic [1:0]          src_is_reg_i,
  input  logic [1:0][RSW-1:0] src_sel_i,
  input  logic                ex_valid_i,
  input  logic [RSW-1:0]      ex_dest_i,
  input  logic                ex_is_load_i,
  input  logic                mem_valid_i,
  input  logic [RSW-1:0]      mem_dest_i,
  output logic [1:0][1:0]     fwd_sel_o,
  output logic                load_use_o
);

  logic [1:0] live;
  logic [1:0] hit_ex;
  logic [1:0] hit_mem;

  for (genvar g = 0; g < 2; g++) begin : g_op
    // Immediates and r0 never depend on an in-flight result
    assign live[g]    = src_is_reg_i[g] && (src_sel_i[g] != RSW'(REGISTER_ZERO));
    assign hit_ex[g]  = live[g] && ex_valid_i  && (src_sel_i[g] == ex_dest_i);
    assign hit_mem[g] = live[g] && mem_valid_i && (src_sel_i[g] == mem_dest_i);
    // The younger (EX) result shadows an older MEM write to the same register
    assign fwd_sel_o[g] = hit_ex[g]  ? FORWARD_EX_MEM :
                          hit_mem[g] ? FORWARD_MEM_WB : FORWARD_REGISTER_FILE;
  end

  // A load in EX has no data until MEM/WB, so a dependent ID op must wait a cycle
  assign load_use_o = ex_valid_i && ex_is_load_i && (|hit_ex);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Sequencing controller for the IF/ID/EX/MEM/WB datapath: destination tracking,
// forwarding selects, load-use stall, branch squash and reset-hold/run/halt FSM.
module pipeline_hazard_controller
  import pipeline_control_package::*;
#(
  parameter int REGISTER_SELECTOR_WIDTH = 5,
  parameter int SOURCE_SELECTOR_WIDTH   = 2,
  parameter int FLUSH_CYCLES            = 2,
  parameter int RESET_HOLD_CYCLES       = 4,
  parameter int STALL_COUNTER_WIDTH     = 16
) (
  input logic clock,
  input logic reset_n,
  pipeline_hazard_controller_if.slave ctl
);

  localparam int RSW   = REGISTER_SELECTOR_WIDTH;
  localparam int SSW   = SOURCE_SELECTOR_WIDTH;
  localparam int SCW   = STALL_COUNTER_WIDTH;
  localparam int CNT_W = $clog2(max_int(RESET_HOLD_CYCLES, FLUSH_CYCLES) + 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_pending_q, halt_pending_d;
  logic [SCW-1:0]   stall_count_q, stall_count_d;

  logic             ex_valid_q, ex_is_load_q, mem_valid_q;
  logic [RSW-1:0]   ex_dest_q, mem_dest_q;

  logic             pc_en, ifid_en, ifid_flush, bubble, halted, count_inc;
  logic [1:0][1:0]  fwd_sel;
  logic             load_use;

  hazard_forwarding_unit #(.RSW(RSW)) u_fwd (
    .src_is_reg_i ({ctl.id_input_type_2, ctl.id_input_type_1}),
    .src_sel_i    ({ctl.id_input_register_selector_2, ctl.id_input_register_selector_1}),
    .ex_valid_i   (ex_valid_q),
    .ex_dest_i    (ex_dest_q),
    .ex_is_load_i (ex_is_load_q),
    .mem_valid_i  (mem_valid_q),
    .mem_dest_i   (mem_dest_q),
    .fwd_sel_o    (fwd_sel),
    .load_use_o   (load_use)
  );

  // FSM next state and buffer-enable decode; RUN outputs depend on this cycle's hazards
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    halt_pending_d = halt_pending_q;
    pc_en          = 1'b0;
    ifid_en        = 1'b0;
    ifid_flush     = 1'b0;
    bubble         = 1'b1;
    halted         = 1'b0;
    count_inc      = 1'b0;
    case (state_q)
      STATE_RESET_HOLD: begin
        ifid_flush = 1'b1;
        if (cnt_q == '0) state_d = STATE_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      STATE_RUN: begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        bubble  = 1'b0;
        // Taken branch squashes the dependent op, so a coincident load-use is moot
        if (ctl.branch_taken) begin
          state_d = STATE_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end else if (load_use) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          bubble    = 1'b1;
          count_inc = 1'b1;
          state_d   = STATE_STALL;
        end else if (ctl.halt_request || halt_pending_q) begin
          state_d        = STATE_HALTED;
          halt_pending_d = 1'b0;
        end
      end
      STATE_STALL: begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        bubble    = 1'b0;
        count_inc = 1'b1;
        state_d   = STATE_RUN;
        if (ctl.halt_request) halt_pending_d = 1'b1;
      end
      STATE_FLUSH: begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        count_inc  = 1'b1;
        if (ctl.halt_request) halt_pending_d = 1'b1;
        if (cnt_q == '0) state_d = STATE_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      STATE_HALTED: begin
        halted = 1'b1;
        if (ctl.resume_request) state_d = STATE_RUN;
      end
      default: begin
        ifid_flush = 1'b1;
        state_d    = STATE_RESET_HOLD;
        cnt_d      = CNT_W'(RESET_HOLD_CYCLES - 1);
      end
    endcase
    stall_count_d = (count_inc && (stall_count_q != '1)) ? stall_count_q + SCW'(1)
                                                         : stall_count_q;
  end

  // FSM, hold/flush counter, pending halt and saturating stall counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= STATE_RESET_HOLD;
      cnt_q          <= CNT_W'(RESET_HOLD_CYCLES - 1);
      halt_pending_q <= 1'b0;
      stall_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      halt_pending_q <= halt_pending_d;
      stall_count_q  <= stall_count_d;
    end
  end

  // Destination tracking shadows the ID/EX and EX/MEM buffers; a bubble enters EX empty
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q   <= 1'b0;
      ex_dest_q    <= '0;
      ex_is_load_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_dest_q   <= '0;
    end else begin
      mem_valid_q  <= ex_valid_q;
      mem_dest_q   <= ex_dest_q;
      ex_valid_q   <= !bubble && ctl.id_output_enable &&
                      (ctl.id_output_register_selector != RSW'(REGISTER_ZERO));
      ex_dest_q    <= bubble ? '0 : ctl.id_output_register_selector;
      ex_is_load_q <= !bubble && (ctl.id_output_source_selector == SSW'(SOURCE_MEMORY));
    end
  end

  assign ctl.pc_enable        = pc_en;
  assign ctl.if_id_enable     = ifid_en;
  assign ctl.if_id_flush      = ifid_flush;
  assign ctl.id_ex_bubble     = bubble;
  assign ctl.forward_select_1 = fwd_sel[0];
  assign ctl.forward_select_2 = fwd_sel[1];
  assign ctl.halted           = halted;
  assign ctl.stall_count      = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: inputs change on the falling
// edge, outputs are checked 1 time unit later, state commits on the rising edge.
module tb_pipeline_hazard_controller;

  logic clock;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  pipeline_hazard_controller_if #(.RSW(5), .SSW(2), .SCW(16)) bus ();

  pipeline_hazard_controller #(
    .REGISTER_SELECTOR_WIDTH(5),
    .SOURCE_SELECTOR_WIDTH  (2),
    .FLUSH_CYCLES           (2),
    .RESET_HOLD_CYCLES      (4),
    .STALL_COUNTER_WIDTH    (16)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .ctl    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic t1, input logic [4:0] s1, input logic t2, input logic [4:0] s2,
                        input logic oe, input logic [1:0] src, input logic [4:0] dst);
    bus.id_input_type_1              = t1;
    bus.id_input_register_selector_1 = s1;
    bus.id_input_type_2              = t2;
    bus.id_input_register_selector_2 = s2;
    bus.id_output_enable             = oe;
    bus.id_output_source_selector    = src;
    bus.id_output_register_selector  = dst;
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    bus.branch_taken   = 1'b0;
    bus.halt_request   = 1'b0;
    bus.resume_request = 1'b0;
    #2;
    chk("rst_pc", bus.pc_enable, 0);
    chk("rst_ifid", bus.if_id_enable, 0);
    chk("rst_flush", bus.if_id_flush, 1);
    chk("rst_bubble", bus.id_ex_bubble, 1);
    chk("rst_fwd1", bus.forward_select_1, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_count", bus.stall_count, 0);

    // Release reset: four held cycles, running on the fifth
    step(); reset_n = 1'b1; settle();
    chk("hold_pc_c1", bus.pc_enable, 0);
    chk("hold_flush_c1", bus.if_id_flush, 1);
    for (int i = 2; i <= 4; i++) begin
      step(); settle();
      chk($sformatf("hold_pc_c%0d", i), bus.pc_enable, 0);
      chk($sformatf("hold_flush_c%0d", i), bus.if_id_flush, 1);
    end

    // ADD r3
    step(); set_id(0, 0, 0, 0, 1, 2'd0, 5'd3); settle();
    chk("run_pc", bus.pc_enable, 1);
    chk("run_flush", bus.if_id_flush, 0);
    chk("run_bubble", bus.id_ex_bubble, 0);
    // ADD r4,r3,r3: r3 in EX
    step(); set_id(1, 5'd3, 1, 5'd3, 1, 2'd0, 5'd4); settle();
    chk("fwd_ex_1", bus.forward_select_1, 1);
    chk("fwd_ex_2", bus.forward_select_2, 1);
    // read r3 (now MEM) and r4 (now EX)
    step(); set_id(1, 5'd3, 1, 5'd4, 0, 2'd0, 5'd0); settle();
    chk("fwd_mem_1", bus.forward_select_1, 2);
    chk("fwd_ex_r4", bus.forward_select_2, 1);
    // immediate operand never forwards; r4 now in MEM
    step(); set_id(0, 5'd4, 1, 5'd4, 0, 2'd0, 5'd0); settle();
    chk("fwd_imm", bus.forward_select_1, 0);
    chk("fwd_mem_r4", bus.forward_select_2, 2);

    // Load into r0 then read r0: no forward, no stall
    step(); set_id(0, 0, 0, 0, 1, 2'd3, 5'd0); settle();
    step(); set_id(1, 5'd0, 1, 5'd0, 0, 2'd0, 5'd0); settle();
    chk("r0_fwd1", bus.forward_select_1, 0);
    chk("r0_fwd2", bus.forward_select_2, 0);
    chk("r0_pc", bus.pc_enable, 1);
    chk("r0_count", bus.stall_count, 0);

    // LOAD r5 then ADD r6,r5,r1
    step(); set_id(0, 0, 0, 0, 1, 2'd3, 5'd5); settle();
    step(); set_id(1, 5'd5, 1, 5'd1, 1, 2'd0, 5'd6); settle();
    chk("lu_pc", bus.pc_enable, 0);
    chk("lu_ifid", bus.if_id_enable, 0);
    chk("lu_bubble", bus.id_ex_bubble, 1);
    chk("lu_count0", bus.stall_count, 0);
    step(); settle();
    chk("stall_pc", bus.pc_enable, 1);
    chk("stall_bubble", bus.id_ex_bubble, 0);
    chk("stall_fwd1", bus.forward_select_1, 2);
    chk("stall_fwd2", bus.forward_select_2, 0);
    chk("stall_count1", bus.stall_count, 1);
    step(); set_id(0, 0, 0, 0, 0, 2'd0, 5'd0); settle();
    chk("post_stall_count", bus.stall_count, 2);
    chk("post_stall_pc", bus.pc_enable, 1);

    // Branch with coincident load-use: flush wins
    step(); set_id(0, 0, 0, 0, 1, 2'd3, 5'd7); settle();
    step(); set_id(1, 5'd7, 0, 0, 1, 2'd0, 5'd9); bus.branch_taken = 1'b1; settle();
    chk("br_pc", bus.pc_enable, 1);
    chk("br_bubble", bus.id_ex_bubble, 0);
    chk("br_count", bus.stall_count, 2);
    // first flush cycle, halt request arrives
    step(); bus.branch_taken = 1'b0; bus.halt_request = 1'b1; set_id(0, 0, 0, 0, 0, 2'd0, 5'd0); settle();
    chk("fl1_flush", bus.if_id_flush, 1);
    chk("fl1_bubble", bus.id_ex_bubble, 1);
    chk("fl1_pc", bus.pc_enable, 1);
    chk("fl1_count", bus.stall_count, 2);
    step(); bus.halt_request = 1'b0; settle();
    chk("fl2_flush", bus.if_id_flush, 1);
    chk("fl2_halted", bus.halted, 0);
    chk("fl2_count", bus.stall_count, 3);
    // RUN entry cycle: pending halt taken here
    step(); settle();
    chk("runent_flush", bus.if_id_flush, 0);
    chk("runent_halted", bus.halted, 0);
    chk("runent_count", bus.stall_count, 4);
    step(); bus.branch_taken = 1'b1; settle();
    chk("halt_halted", bus.halted, 1);
    chk("halt_pc", bus.pc_enable, 0);
    chk("halt_ifid", bus.if_id_enable, 0);
    chk("halt_bubble", bus.id_ex_bubble, 1);
    step(); bus.branch_taken = 1'b0; bus.resume_request = 1'b1; settle();
    chk("halt_br_ignored", bus.if_id_flush, 0);
    chk("halt_still", bus.halted, 1);
    step(); bus.resume_request = 1'b0; settle();
    chk("resume_halted", bus.halted, 0);
    chk("resume_pc", bus.pc_enable, 1);
    chk("resume_count", bus.stall_count, 4);

    // Reset asserted mid-STALL
    step(); set_id(0, 0, 0, 0, 1, 2'd3, 5'd5); settle();
    step(); set_id(1, 5'd5, 0, 0, 0, 2'd0, 5'd0); settle();
    chk("lu2_pc", bus.pc_enable, 0);
    step(); settle();
    chk("lu2_stall_count", bus.stall_count, 5);
    chk("lu2_stall_fwd", bus.forward_select_1, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_pc", bus.pc_enable, 0);
    chk("mid_rst_flush", bus.if_id_flush, 1);
    chk("mid_rst_bubble", bus.id_ex_bubble, 1);
    chk("mid_rst_fwd1", bus.forward_select_1, 0);
    chk("mid_rst_count", bus.stall_count, 0);
    chk("mid_rst_halted", bus.halted, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
